mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_timeout_cnt.sv | 29 ++
 rtl/mem_access_unit.sv | 118 +++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the memory access unit.
// Control-word bit positions, FSM encoding and opcode field.
package mem_access_unit_pkg;

    localparam int MEMREAD  = 16;
    localparam int MEMWRITE = 15;
    localparam int IRWRITE  = 7;
    localparam int IORD     = 6;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mau_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Busy-cycle counter for the memory access unit.
// Fires on the last permitted busy cycle with no ack.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access unit: issues one registered
// request per access and captures the result into IR or MDR.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [17:0] Ctrl,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] B,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [31:0] IR,
    output logic [31:0] MDR,
    output logic [5:0]  OPCode,
    output logic        Stall,
    output logic        Err
);

    mau_state_t  state;
    logic        ir_wr_q;
    logic        rd;
    logic        wr;
    logic [31:0] addr_sel;
    logic        is_idle;
    logic        is_busy;
    logic        one_op;
    logic        aligned;
    logic        start;
    logic        bad;
    logic        cnt_en;
    logic        expired;
    logic        unused_ctrl;

    assign rd       = Ctrl[MEMREAD];
    assign wr       = Ctrl[MEMWRITE];
    assign addr_sel = Ctrl[IORD] ? ALUOut : PC;
    assign is_idle  = (state == IDLE);
    assign is_busy  = (state == BUSY);
    assign one_op   = rd ^ wr;
    assign aligned  = (addr_sel[1:0] == 2'b00);
    assign start    = is_idle && one_op && aligned;
    assign bad      = is_idle && (rd || wr) && !(one_op && aligned);
    assign cnt_en   = is_busy && !MemAck;

    assign unused_ctrl = ^{Ctrl[17], Ctrl[14:8], Ctrl[5:0]};

    mem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (CLK),
        .rst    (RST),
        .clear  (start),
        .enable (cnt_en),
        .expired(expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            MemReq   <= 1'b0;
            MemWE    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            ir_wr_q  <= 1'b0;
            IR       <= '0;
            MDR      <= '0;
            Err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        MemAddr  <= addr_sel;
                        MemWData <= B;
                        MemWE    <= wr;
                        ir_wr_q  <= Ctrl[IRWRITE];
                        MemReq   <= 1'b1;
                        state    <= BUSY;
                    end else if (bad) begin
                        Err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        MemWE  <= 1'b0;
                        // a write never touches IR or MDR
                        if (!MemWE) begin
                            if (ir_wr_q) IR <= MemRData;
                            else         MDR <= MemRData;
                        end
                        state <= IDLE;
                    end else if (expired) begin
                        Err    <= 1'b1;
                        MemReq <= 1'b0;
                        MemWE  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign OPCode = IR[OPCODE_HI:OPCODE_LO];

    // the abort cycle releases the control unit like an ack
    assign Stall = (is_idle && (rd || wr))
                 || (is_busy && !MemAck && !expired);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a request scoreboard
// and a reference model of IR, MDR and Err.
module tb_mem_access_unit;

    localparam logic [17:0] C_FETCH = 18'h100A2;
    localparam logic [17:0] C_LOAD  = 18'h10040;
    localparam logic [17:0] C_STORE = 18'h08040;
    localparam logic [17:0] C_BOTH  = 18'h18040;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    logic        CLK;
    logic        RST;
    logic [17:0] Ctrl;
    logic [31:0] PC;
    logic [31:0] ALUOut;
    logic [31:0] B;
    logic [31:0] MemRData;
    logic        MemAck;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] IR;
    logic [31:0] MDR;
    logic [5:0]  OPCode;
    logic        Stall;
    logic        Err;

    int n_chk  = 0;
    int n_fail = 0;

    req_t        sb[$];
    logic [31:0] exp_ir;
    logic [31:0] exp_mdr;
    logic        exp_err;

    mem_access_unit #(
        .TIMEOUT(4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Ctrl    (Ctrl),
        .PC      (PC),
        .ALUOut  (ALUOut),
        .B       (B),
        .MemRData(MemRData),
        .MemAck  (MemAck),
        .MemReq  (MemReq),
        .MemWE   (MemWE),
        .MemAddr (MemAddr),
        .MemWData(MemWData),
        .IR      (IR),
        .MDR     (MDR),
        .OPCode  (OPCode),
        .Stall   (Stall),
        .Err     (Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic [17:0] ctrl,
                          input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] b, input int waits,
                          input logic [31:0] rdata);
        req_t r;
        int   stalls;
        @(negedge CLK);
        Ctrl   = ctrl;
        PC     = pc;
        ALUOut = alu;
        B      = b;
        MemAck = 1'b0;
        r.addr  = ctrl[6] ? alu : pc;
        r.we    = ctrl[15];
        r.wdata = b;
        sb.push_back(r);
        stalls = 0;
        #1 if (Stall === 1'b1) stalls++;
        @(posedge CLK);
        @(negedge CLK);
        Ctrl = '0;
        r = sb.pop_front();
        for (int i = 0; i <= waits; i++) begin
            if (i > 0) @(negedge CLK);
            chk({tag, " req"},   32'(MemReq), 32'd1);
            chk({tag, " addr"},  MemAddr,     r.addr);
            chk({tag, " we"},    32'(MemWE),  32'(r.we));
            chk({tag, " wdata"}, MemWData,    r.wdata);
            if (i == waits) begin
                MemAck   = 1'b1;
                MemRData = rdata;
            end
            #1 if (Stall === 1'b1) stalls++;
            @(posedge CLK);
        end
        if (ctrl[16]) begin
            if (ctrl[7]) exp_ir  = rdata;
            else         exp_mdr = rdata;
        end
        @(negedge CLK);
        MemAck   = 1'b0;
        MemRData = 32'hA5A5_5A5A;
        chk({tag, " req done"}, 32'(MemReq), 32'd0);
        chk({tag, " we done"},  32'(MemWE),  32'd0);
        chk({tag, " ir"},       IR,          exp_ir);
        chk({tag, " mdr"},      MDR,         exp_mdr);
        chk({tag, " opcode"},   32'(OPCode), 32'(exp_ir[31:26]));
        chk({tag, " stalls"},   32'(stalls), 32'(waits + 1));
        chk({tag, " err"},      32'(Err),    32'(exp_err));
    endtask

    task automatic bad_req(input string tag, input logic [17:0] ctrl,
                           input logic [31:0] alu);
        @(negedge CLK);
        Ctrl   = ctrl;
        ALUOut = alu;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk({tag, " no req"}, 32'(MemReq), 32'd0);
        end
        Ctrl = '0;
        exp_err = 1'b1;
        #1;
        chk({tag, " err"},  32'(Err),   32'(exp_err));
        chk({tag, " idle"}, 32'(Stall), 32'd0);
    endtask

    initial begin
        int          highs;
        logic        last_stall;
        RST      = 1'b1;
        Ctrl     = '0;
        PC       = '0;
        ALUOut   = '0;
        B        = '0;
        MemRData = '0;
        MemAck   = 1'b0;
        exp_ir   = '0;
        exp_mdr  = '0;
        exp_err  = 1'b0;

        #13;
        chk("rst req",    32'(MemReq),  32'd0);
        chk("rst we",     32'(MemWE),   32'd0);
        chk("rst addr",   MemAddr,      32'd0);
        chk("rst wdata",  MemWData,     32'd0);
        chk("rst ir",     IR,           32'd0);
        chk("rst mdr",    MDR,          32'd0);
        chk("rst err",    32'(Err),     32'd0);
        chk("rst opcode", 32'(OPCode),  32'd0);
        chk("rst stall",  32'(Stall),   32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // ack with no outstanding request
        @(negedge CLK);
        MemAck   = 1'b1;
        MemRData = 32'h5555_5555;
        @(negedge CLK);
        MemAck = 1'b0;
        chk("idle ack req", 32'(MemReq), 32'd0);
        chk("idle ack ir",  IR,          exp_ir);
        chk("idle ack mdr", MDR,         exp_mdr);

        access("fetch", C_FETCH, 32'h0000_0040, 32'h0, 32'h0,
               3, 32'h8C22_0004);
        chk("fetch opc", 32'(OPCode), 32'h23);
        access("load", C_LOAD, 32'h0, 32'h0000_0104, 32'h0,
               0, 32'hDEAD_BEEF);
        access("store", C_STORE, 32'h0, 32'h0000_0200, 32'h1234_5678,
               2, 32'hFFFF_FFFF);

        bad_req("both", C_BOTH, 32'h0000_0100);
        bad_req("misal", C_LOAD, 32'h0000_0102);
        chk("sticky ir",  IR,  exp_ir);
        chk("sticky mdr", MDR, exp_mdr);

        @(negedge CLK);
        RST = 1'b1;
        #1;
        exp_ir  = '0;
        exp_mdr = '0;
        exp_err = 1'b0;
        chk("rst2 err", 32'(Err), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        access("load2", C_LOAD, 32'h0, 32'h0000_0010, 32'h0,
               1, 32'h0BAD_F00D);

        // timeout with no ack
        @(negedge CLK);
        Ctrl   = C_LOAD;
        ALUOut = 32'h0000_0300;
        @(posedge CLK);
        @(negedge CLK);
        Ctrl       = '0;
        highs      = 0;
        last_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (MemReq !== 1'b1) break;
            highs++;
            #1 last_stall = Stall;
            @(negedge CLK);
        end
        exp_err = 1'b1;
        chk("tmo highs", 32'(highs),      32'd4);
        chk("tmo stall", 32'(last_stall), 32'd0);
        chk("tmo req",   32'(MemReq),     32'd0);
        chk("tmo err",   32'(Err),        32'(exp_err));
        chk("tmo ir",    IR,              exp_ir);
        chk("tmo mdr",   MDR,             exp_mdr);

        access("fetch2", C_FETCH, 32'h0000_0080, 32'h0, 32'h0,
               0, 32'h0022_1820);

        // reset pulse between edges during a busy access
        @(negedge CLK);
        Ctrl = C_FETCH;
        PC   = 32'h0000_00C0;
        @(posedge CLK);
        @(negedge CLK);
        Ctrl = '0;
        chk("mid req on", 32'(MemReq), 32'd1);
        #2 RST = 1'b1;
        #1;
        exp_ir  = '0;
        exp_mdr = '0;
        exp_err = 1'b0;
        chk("mid req",   32'(MemReq), 32'd0);
        chk("mid ir",    IR,          32'd0);
        chk("mid mdr",   MDR,         32'd0);
        chk("mid err",   32'(Err),    32'd0);
        chk("mid stall", 32'(Stall),  32'd0);
        @(negedge CLK);
        RST = 1'b0;

        access("fetch3", C_FETCH, 32'h0000_0044, 32'h0, 32'h0,
               1, 32'h8C22_0008);
        chk("sb empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
